// File: rtl/countdown_display.sv
// countdown_display
//   Scans a two-digit countdown value, a phase indicator and a blank digit
//   onto a 4-digit, common-anode seven-segment display. It also drives the
//   red/yellow/green lamps.
//
//   The binary seconds value goes through a one-cycle capture stage. It is
//   then clamped to 99 and converted to BCD by a double-dabble FSM
//   (IDLE -> SHIFT x7 -> LOAD). The conversion runs only when the value
//   differs from the last one converted. A prescaler sets the digit scan
//   rate.
//
//   Latency: a value sampled on capture edge k reaches tens/units on edge
//   k+9. Edge k+1 is the IDLE decision, edges k+2..k+8 are the seven shifts,
//   and edge k+9 is LOAD.
//
// Ports
//   CLK     in   1  clock, rising edge
//   RST_N   in   1  asynchronous active-low reset
//   En      in   1  countdown running; when low, the number digits show "-"
//                   and the lamps are off
//   Q       in   7  remaining seconds, binary; values above 99 show as 99
//   select  in   2  phase: 00 green, 01 yellow, 11 red, 10 illegal
//   SEG     out  7  {g,f,e,d,c,b,a}, active-low, registered
//   AN      out  4  digit enables, active-low one-hot, AN[0] rightmost
//   LIGHT   out  3  {red,yellow,green}, active-high, registered
module countdown_display #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       En,
  input  logic [6:0] Q,
  input  logic [1:0] select,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic [2:0] LIGHT
);

  localparam logic [1:0]  ST_IDLE   = 2'b00;
  localparam logic [1:0]  ST_SHIFT  = 2'b01;
  localparam logic [1:0]  ST_LOAD   = 2'b10;
  localparam logic [2:0]  SH_LAST   = 3'd6;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [15:0] SCAN_LAST = SCAN_DIV - 16'd1;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before
  // the shift, so that it carries correctly into the next decade.
  function automatic logic [7:0] bcd_adjust(input logic [7:0] bcd);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    lo = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    return {hi, lo};
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] phase_seg(input logic [1:0] sel);
    logic [6:0] s;
    case (sel)
      2'b00:   s = seg_encode(4'd1);
      2'b01:   s = seg_encode(4'd2);
      2'b11:   s = seg_encode(4'd3);
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] lamp(input logic en, input logic [1:0] sel);
    logic [2:0] l;
    if (!en) begin
      l = 3'b000;
    end else begin
      case (sel)
        2'b00:   l = 3'b001;
        2'b01:   l = 3'b010;
        2'b11:   l = 3'b100;
        default: l = 3'b000;
      endcase
    end
    return l;
  endfunction

  logic       en_p0;
  logic [6:0] q_p0;
  logic [1:0] sel_p0;

  // ---- stage p0: input capture ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      en_p0  <= 1'b0;
      q_p0   <= 7'd0;
      sel_p0 <= 2'b00;
    end else begin
      en_p0  <= En;
      q_p0   <= Q;
      sel_p0 <= select;
    end
  end

  logic [6:0] q_sat_p0;
  assign q_sat_p0 = sat99(q_p0);

  logic [1:0] state;
  logic [2:0] sh_cnt;
  logic [7:0] scr_bcd;
  logic [6:0] scr_bin;
  logic [6:0] conv_val;
  logic [3:0] tens_r;
  logic [3:0] units_r;
  logic [6:0] last_r;
  logic       start;
  logic [7:0] bcd_adj;

  // The comparison is made only in IDLE. A new Q that arrives mid-conversion
  // is picked up in the first IDLE cycle after LOAD.
  assign start   = (state == ST_IDLE) && (q_sat_p0 != last_r);
  assign bcd_adj = bcd_adjust(scr_bcd);

  // ---- converter: BCD FSM control and result registers ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      sh_cnt  <= 3'd0;
      tens_r  <= 4'd0;
      units_r <= 4'd0;
      last_r  <= 7'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          sh_cnt <= 3'd0;
          if (start) begin
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sh_cnt <= sh_cnt + 3'd1;
          if (sh_cnt == SH_LAST) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tens_r  <= scr_bcd[7:4];
          units_r <= scr_bcd[3:0];
          last_r  <= conv_val;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Scratch datapath. It is always loaded on start before it is read, so it
  // carries no reset.
  always_ff @(posedge CLK) begin
    if (start) begin
      scr_bcd  <= 8'd0;
      scr_bin  <= q_sat_p0;
      conv_val <= q_sat_p0;
    end else if (state == ST_SHIFT) begin
      {scr_bcd, scr_bin} <= {bcd_adj[6:0], scr_bin, 1'b0};
    end
  end

  logic [15:0] pre_cnt;
  logic [1:0]  dig_idx;
  logic        tick;

  assign tick = (pre_cnt == SCAN_LAST);

  // ---- scan: prescaler and digit index ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_cnt <= 16'd0;
      dig_idx <= 2'd0;
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      dig_idx <= dig_idx + {1'b0, tick};
    end
  end

  logic [6:0] seg_nxt;

  always_comb begin
    seg_nxt = SEG_BLANK;
    case (dig_idx)
      2'd0: seg_nxt = en_p0 ? seg_encode(units_r) : SEG_DASH;
      2'd1: begin
        if (!en_p0) begin
          seg_nxt = SEG_DASH;
        end else if (tens_r == 4'd0) begin
          seg_nxt = SEG_BLANK;
        end else begin
          seg_nxt = seg_encode(tens_r);
        end
      end
      2'd2:    seg_nxt = phase_seg(sel_p0);
      default: seg_nxt = SEG_BLANK;
    endcase
  end

  // ---- stage p1: registered display and lamp outputs ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SEG   <= SEG_BLANK;
      AN    <= 4'b1111;
      LIGHT <= 3'b000;
    end else begin
      SEG   <= seg_nxt;
      AN    <= ~(4'b0001 << dig_idx);
      LIGHT <= lamp(en_p0, sel_p0);
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
// Testbench for countdown_display with SCAN_DIV = 4.
// A behavioural model tracks the outputs from edge counts and decimal
// arithmetic. A compare process checks SEG/AN/LIGHT on every falling edge.
// Directed literal expectations pin the model.
module tb_countdown_display;

  localparam int SDI = 4;

  logic       CLK    = 1'b0;
  logic       RST_N  = 1'b1;
  logic       En     = 1'b0;
  logic [6:0] Q      = 7'd0;
  logic [1:0] select = 2'b00;
  logic [6:0] SEG;
  logic [3:0] AN;
  logic [2:0] LIGHT;

  countdown_display #(.SCAN_DIV(16'(SDI))) dut (
    .CLK(CLK), .RST_N(RST_N), .En(En), .Q(Q), .select(select),
    .SEG(SEG), .AN(AN), .LIGHT(LIGHT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Encodings: index 0..9 are digits, 10 is dash, 11 is blank.
  function automatic logic [6:0] enc(input int ch);
    logic [6:0] t [0:11];
    t[0] = 7'b1000000; t[1] = 7'b1111001; t[2]  = 7'b0100100; t[3]  = 7'b0110000;
    t[4] = 7'b0011001; t[5] = 7'b0010010; t[6]  = 7'b0000010; t[7]  = 7'b1111000;
    t[8] = 7'b0000000; t[9] = 7'b0010000; t[10] = 7'b0111111; t[11] = 7'b1111111;
    return t[ch];
  endfunction

  function automatic int clamp99(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic logic [6:0] model_digit(input int pos, input int tens, input int units,
                                             input bit en, input logic [1:0] sel);
    if (pos == 3) return enc(11);
    if (pos == 2) begin
      if (sel == 2'b00) return enc(1);
      if (sel == 2'b01) return enc(2);
      if (sel == 2'b11) return enc(3);
      return enc(10);
    end
    if (!en) return enc(10);
    if (pos == 1) return (tens == 0) ? enc(11) : enc(tens);
    return enc(units);
  endfunction

  function automatic logic [2:0] model_lamp(input bit en, input logic [1:0] sel);
    if (!en) return 3'b000;
    if (sel == 2'b00) return 3'b001;
    if (sel == 2'b01) return 3'b010;
    if (sel == 2'b11) return 3'b100;
    return 3'b000;
  endfunction

  // ---------------- behavioural model ----------------
  int         m_edges, m_capq, m_tens, m_units, m_last, m_pend, m_finish;
  bit         m_cape, m_busy;
  logic [1:0] m_caps;
  int         pq, pt, pu, pidx;
  bit         pe;
  logic [1:0] ps;
  logic [6:0] exp_seg   = 7'h7F;
  logic [3:0] exp_an    = 4'hF;
  logic [2:0] exp_light = 3'b000;

  initial begin
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        m_edges = 0; m_capq = 0; m_cape = 0; m_caps = 2'b00;
        m_tens = 0; m_units = 0; m_last = 0; m_pend = 0; m_finish = 0; m_busy = 0;
        exp_seg = 7'h7F; exp_an = 4'hF; exp_light = 3'b000;
      end else begin
        pq = m_capq; pe = m_cape; ps = m_caps; pt = m_tens; pu = m_units;
        pidx = (m_edges / SDI) % 4;
        m_edges++;
        // A conversion starts one edge after the capture and finishes 8 edges later.
        if (m_busy) begin
          if (m_edges == m_finish) begin
            m_tens = m_pend / 10; m_units = m_pend % 10; m_last = m_pend; m_busy = 0;
          end
        end else if (clamp99(pq) != m_last) begin
          m_busy = 1; m_pend = clamp99(pq); m_finish = m_edges + 8;
        end
        m_capq = int'(Q); m_cape = En; m_caps = select;
        exp_an    = ~(4'b0001 << pidx);
        exp_seg   = model_digit(pidx, pt, pu, pe, ps);
        exp_light = model_lamp(pe, ps);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK);
      check("seg", 32'(SEG), 32'(exp_seg));
      check("an", 32'(AN), 32'(exp_an));
      check("light", 32'(LIGHT), 32'(exp_light));
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_digit(input string name, input logic [3:0] an, input logic [6:0] seg);
    bit found;
    found = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK);
      if (AN === an) begin
        found = 1;
        break;
      end
    end
    if (found) begin
      check(name, 32'(SEG), 32'(seg));
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: AN never reached %b, last AN=%b", name, an, AN);
    end
  endtask

  logic [1:0] sw_sel [0:3];
  logic [2:0] sw_lamp [0:3];
  logic [6:0] sw_d2 [0:3];

  initial begin
    sw_sel[0] = 2'b00; sw_lamp[0] = 3'b001; sw_d2[0] = 7'b1111001;
    sw_sel[1] = 2'b01; sw_lamp[1] = 3'b010; sw_d2[1] = 7'b0100100;
    sw_sel[2] = 2'b10; sw_lamp[2] = 3'b000; sw_d2[2] = 7'b0111111;
    sw_sel[3] = 2'b11; sw_lamp[3] = 3'b100; sw_d2[3] = 7'b0110000;

    #1 RST_N = 1'b0;
    settle(3);
    check("rst_seg", 32'(SEG), 32'h7F);
    check("rst_an", 32'(AN), 32'hF);
    check("rst_light", 32'(LIGHT), 32'h0);

    // 57: latency pin, then the scan pattern
    En = 1'b1; select = 2'b00; Q = 7'd57;
    RST_N = 1'b1;
    repeat (9) @(posedge CLK);
    #1 check("lat_not_yet", 32'(m_last), 32'd0);
    @(posedge CLK);
    #1 check("lat_last57", 32'(m_last), 32'd57);
    check("lat_tens5", 32'(m_tens), 32'd5);
    check("lat_units7", 32'(m_units), 32'd7);
    settle(4);
    expect_digit("q57_d0", 4'b1110, 7'b1111000);
    expect_digit("q57_d1", 4'b1101, 7'b0010010);
    expect_digit("q57_d2", 4'b1011, 7'b1111001);
    expect_digit("q57_d3", 4'b0111, 7'b1111111);
    check("q57_light", 32'(LIGHT), 32'b001);

    Q = 7'd5;  settle(14);
    expect_digit("q5_d1_blank", 4'b1101, 7'b1111111);
    expect_digit("q5_d0", 4'b1110, 7'b0010010);
    Q = 7'd0;  settle(14);
    expect_digit("q0_d0", 4'b1110, 7'b1000000);
    Q = 7'd120; settle(14);
    expect_digit("q120_d0", 4'b1110, 7'b0010000);
    expect_digit("q120_d1", 4'b1101, 7'b0010000);

    // Q changes during SHIFT: the first LOAD keeps 57, a second conversion gives 42
    Q = 7'd10; settle(14);
    Q = 7'd57;
    @(posedge CLK);
    repeat (3) @(negedge CLK);
    Q = 7'd42;
    repeat (7) @(posedge CLK);
    #1 check("chg_first57", 32'(m_last), 32'd57);
    repeat (8) @(posedge CLK);
    #1 check("chg_still57", 32'(m_last), 32'd57);
    @(posedge CLK);
    #1 check("chg_then42", 32'(m_last), 32'd42);
    settle(2);
    expect_digit("q42_d0", 4'b1110, 7'b0100100);
    expect_digit("q42_d1", 4'b1101, 7'b0011001);

    // select sweep
    for (int i = 0; i < 4; i++) begin
      select = sw_sel[i];
      settle(3);
      check("sweep_light", 32'(LIGHT), 32'(sw_lamp[i]));
      expect_digit("sweep_d2", 4'b1011, sw_d2[i]);
    end

    // En low
    select = 2'b00; En = 1'b0; settle(3);
    check("en0_light", 32'(LIGHT), 32'b000);
    expect_digit("en0_d0", 4'b1110, 7'b0111111);
    expect_digit("en0_d1", 4'b1101, 7'b0111111);
    En = 1'b1;

    // asynchronous reset in the middle of a conversion
    Q = 7'd33;
    repeat (3) @(posedge CLK);
    #3 RST_N = 1'b0;
    #1 check("arst_seg", 32'(SEG), 32'h7F);
    check("arst_an", 32'(AN), 32'hF);
    check("arst_light", 32'(LIGHT), 32'h0);
    settle(2);
    RST_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1 check("arst_conv33", 32'(m_last), 32'd33);
    settle(2);
    expect_digit("q33_d0", 4'b1110, 7'b0110000);
    expect_digit("q33_d1", 4'b1101, 7'b0110000);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 5) == 0) Q = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 19) == 0) select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) En = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) RST_N = 1'b0;
      else RST_N = 1'b1;
    end
    RST_N = 1'b1;
    settle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
